// File: rtl/spi_reg_pkg.sv
// Shared types and command-field helpers for the SPI register bank.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    CMD = 2'd0,
    WR  = 2'd1,
    RD  = 2'd2
  } state_t;

  // Command word layout: {rw, addr[WIDTH-2:0]}
  function automatic int unsigned cmd_rw_bit(input int unsigned width);
    return width - 1;
  endfunction

  function automatic int unsigned cmd_addr_msb(input int unsigned width);
    return width - 2;
  endfunction

  function automatic logic in_range(input int unsigned addr, input int unsigned num_regs);
    return addr < num_regs;
  endfunction

  // In-range pointers wrap at the top of the bank; out-of-range pointers stick.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned num_regs);
    if (ptr >= num_regs) return ptr;
    return (ptr == num_regs - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/spi_reg_bank_if.sv
// Word-level link between the SPI shift-register slave (master side) and the
// register bank (slave side). Optional write-strobe signals exist only when
// SPI_REG_BANK_WSTRB_EN is defined.
interface spi_reg_bank_if #(
  parameter int unsigned WIDTH = 8
);
  logic             cs_n;
  logic             rx_valid;
  logic [WIDTH-1:0] rx_data;
  logic             tx_load;
  logic [WIDTH-1:0] tx_data;
  logic             addr_err;
`ifdef SPI_REG_BANK_WSTRB_EN
  logic             wr_stb;
  logic [WIDTH-2:0] wr_addr;

  modport master (output cs_n, rx_valid, rx_data,
                  input  tx_load, tx_data, addr_err, wr_stb, wr_addr);
  modport slave  (input  cs_n, rx_valid, rx_data,
                  output tx_load, tx_data, addr_err, wr_stb, wr_addr);
`else
  modport master (output cs_n, rx_valid, rx_data,
                  input  tx_load, tx_data, addr_err);
  modport slave  (input  cs_n, rx_valid, rx_data,
                  output tx_load, tx_data, addr_err);
`endif
endinterface

// File: rtl/spi_reg_file.sv
// Register array with one write port, one combinational read port (0 when
// out of range) and a flat export of all registers.
module spi_reg_file
  import spi_reg_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      NUM_REGS  = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      sclk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [WIDTH-2:0]          waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [WIDTH-2:0]          raddr,
  output logic [WIDTH-1:0]          rdata,
  output logic [NUM_REGS*WIDTH-1:0] regs_o
);

  localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [WIDTH-1:0] mem [NUM_REGS];

  // Storage: reset to RESET_VAL, written only for in-range addresses
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) mem[i] <= RESET_VAL;
    end else if (we && in_range(32'(waddr), NUM_REGS)) begin
      mem[AW'(waddr)] <= wdata;
    end
  end

  // Read port: out-of-range addresses read as zero
  always_comb begin
    rdata = '0;
    if (in_range(32'(raddr), NUM_REGS)) rdata = mem[AW'(raddr)];
  end

  // Flat export, reg i at [i*WIDTH +: WIDTH]
  always_comb begin
    regs_o = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) regs_o[i*WIDTH +: WIDTH] = mem[i];
  end

endmodule

// File: rtl/spi_reg_bank.sv
// Command/register stage behind the SPI slave: decodes {rw, addr} command
// words followed by auto-incrementing data words. Optional write strobe
// outputs are enabled by defining SPI_REG_BANK_WSTRB_EN.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      NUM_REGS  = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      sclk,
  input  logic                      rst,
  spi_reg_bank_if.slave             bus,
  output logic [NUM_REGS*WIDTH-1:0] regs_o
);

  localparam int unsigned PW     = WIDTH - 1;
  localparam int unsigned RW_BIT = cmd_rw_bit(WIDTH);
  localparam int unsigned AMSB   = cmd_addr_msb(WIDTH);

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic             tx_load_q, tx_load_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] tx_data_q, tx_data_d;
  logic             wr_stb_q, wr_stb_d;
  logic [PW-1:0]    wr_addr_q, wr_addr_d;
  logic             we;
  logic [PW-1:0]    raddr;
  logic [WIDTH-1:0] rdata;
  logic             cs_n;
  logic             word_ok;
  logic [PW-1:0]    cmd_addr;
  logic             cmd_rw;

  assign cs_n     = bus.cs_n;
  assign word_ok  = bus.rx_valid & ~cs_n;
  assign cmd_addr = bus.rx_data[AMSB:0];
  assign cmd_rw   = bus.rx_data[RW_BIT];

  spi_reg_file #(
    .WIDTH     (WIDTH),
    .NUM_REGS  (NUM_REGS),
    .RESET_VAL (RESET_VAL)
  ) u_file (
    .sclk   (sclk),
    .rst    (rst),
    .we     (we),
    .waddr  (ptr_q),
    .wdata  (bus.rx_data),
    .raddr  (raddr),
    .rdata  (rdata),
    .regs_o (regs_o)
  );

  // Next state, pointer and output pulses for each accepted word
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    tx_load_d = 1'b0;
    err_d     = 1'b0;
    tx_data_d = tx_data_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    we        = 1'b0;
    raddr     = ptr_q;
    if (word_ok) begin
      case (state_q)
        CMD: begin
          ptr_d = cmd_addr;
          if (cmd_rw) begin
            state_d   = RD;
            raddr     = cmd_addr;
            tx_data_d = rdata;
            tx_load_d = 1'b1;
            err_d     = ~in_range(32'(cmd_addr), NUM_REGS);
            ptr_d     = PW'(ptr_next(32'(cmd_addr), NUM_REGS));
          end else begin
            state_d = WR;
          end
        end
        WR: begin
          we       = in_range(32'(ptr_q), NUM_REGS);
          err_d    = ~we;
          wr_stb_d = we;
          if (we) wr_addr_d = ptr_q;
          ptr_d    = PW'(ptr_next(32'(ptr_q), NUM_REGS));
        end
        RD: begin
          tx_data_d = rdata;
          tx_load_d = 1'b1;
          err_d     = ~in_range(32'(ptr_q), NUM_REGS);
          ptr_d     = PW'(ptr_next(32'(ptr_q), NUM_REGS));
        end
        default: state_d = CMD;
      endcase
    end
  end

  // Frame state and pulses: cleared by rst or by chip-select deassertion
  always_ff @(posedge sclk or posedge rst or posedge cs_n) begin
    if (rst) begin
      state_q   <= CMD;
      ptr_q     <= '0;
      tx_load_q <= 1'b0;
      err_q     <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
    end else if (cs_n) begin
      state_q   <= CMD;
      ptr_q     <= '0;
      tx_load_q <= 1'b0;
      err_q     <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      tx_load_q <= tx_load_d;
      err_q     <= err_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  // Transmit word survives chip-select deassertion; only rst clears it
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) tx_data_q <= '0;
    else     tx_data_q <= tx_data_d;
  end

  assign bus.tx_load  = tx_load_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.addr_err = err_q;
`ifdef SPI_REG_BANK_WSTRB_EN
  assign bus.wr_stb   = wr_stb_q;
  assign bus.wr_addr  = wr_addr_q;
`endif

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- Command/register stage directly downstream of the team's SPI shift-register slave, in the same sclk domain.
- Consumes each received word (rx_valid/rx_data) and decodes frames of the form command word, then data words.
- Maintains a bank of NUM_REGS writable registers, exported flat to the fabric.
- Returns read data to the slave's transmit side via tx_load/tx_data.

Parameters:
- WIDTH, 8, SPI word width; command = {rw, addr[WIDTH-2:0]}.
- NUM_REGS, 16, number of registers; legal range 1..2**(WIDTH-1).
- RESET_VAL, 0, value loaded into every register on rst.

Ports:
- sclk  in  1  SPI clock; all sequential logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- cs_n  in  1  chip select, active-low; high also asynchronously clears frame state.
- rx_valid  in  1  one-sclk pulse: rx_data holds a complete received word.
- rx_data  in  WIDTH  received word.
- tx_load  out  1  one-cycle pulse: tx_data is a new word for the transmit shifter.
- tx_data  out  WIDTH  read data word, held stable between tx_load pulses.
- regs_o  out  NUM_REGS*WIDTH  register contents; reg i at bits [i*WIDTH +: WIDTH].
- addr_err  out  1  one-cycle pulse on any access to addr >= NUM_REGS.

Behaviour:
- Reset (rst=1, async):
  - all registers = RESET_VAL; state = CMD; ptr = 0.
  - tx_load = 0, tx_data = 0, addr_err = 0.
- cs_n=1 (async, in addition to rst): clears state to CMD and ptr to 0.
  - Registers, tx_data and regs_o are NOT affected.
  - tx_load and addr_err are forced to 0.
- FSM states: CMD, WR, RD. Transitions occur only on posedge sclk with rx_valid=1 and cs_n=0; with rx_valid=0, state and outputs hold (pulses drop to 0).
- CMD, rx_valid:
  - ptr <= rx_data[WIDTH-2:0].
  - If rx_data[WIDTH-1]=0: go to WR; no register change.
  - If rx_data[WIDTH-1]=1: go to RD; tx_data <= reg[addr] (0 if out of range); tx_load <= 1; ptr <= addr+1.
- WR, rx_valid:
  - reg[ptr] <= rx_data, visible on regs_o after this same edge (latency 1 edge); ptr <= ptr+1.
  - State stays WR until cs_n=1.
- RD, rx_valid:
  - rx_data is ignored.
  - tx_data <= reg[ptr] (0 if out of range); tx_load <= 1; ptr <= ptr+1; stays RD.
- Pointer arithmetic: ptr is WIDTH-1 bits.
  - If ptr < NUM_REGS: increment wraps NUM_REGS-1 -> 0.
  - If ptr >= NUM_REGS: increment saturates; ptr stays out of range for the rest of the frame.
- Out of range (ptr >= NUM_REGS):
  - writes dropped; reads return 0.
  - addr_err pulses for 1 cycle on each such access; for a read command this includes the command word itself.
- Read-after-write: a register written in frame N is readable from frame N+1.
- No read-modify-write exists within a frame.
- Reset mid-frame: rst wins over everything, including a write on the same edge.
- cs_n rising mid-word: a partial word never raises rx_valid; nothing is written.
- rx_valid=1 while cs_n=1: ignored (frame state held cleared).

Optional Feature:
- Macro: SPI_REG_BANK_WSTRB_EN.
- Defined:
  - adds outputs wr_stb (1 bit) and wr_addr (WIDTH-1 bits).
  - wr_stb pulses for 1 cycle on each accepted in-range register write; wr_addr = the address written; same edge as the register update.
  - Reset value 0 for both; cleared by cs_n=1 like tx_load.
- Undefined: ports absent; behaviour otherwise identical.

Decomposition:
- Package spi_reg_pkg:
  - typedef enum state_t {CMD, WR, RD}.
  - constant/functions for the command field layout: rw bit = WIDTH-1; addr bits = WIDTH-2:0.
  - function ptr_next(ptr, NUM_REGS), implementing wrap/saturate.
- One natural sub-module: spi_reg_file. It holds the register array and regs_o flattening, with a single write port and a combinational read port returning 0 when out of range. The FSM and pointer stay in spi_reg_bank.

Test Plan:
1. rst pulse -> all regs_o fields = RESET_VAL, tx_load = 0, tx_data = 0, addr_err = 0.
2. Frame cs_n=0, words 0x03, 0xA5, 0x5A, then cs_n=1 -> reg3 = 0xA5, reg4 = 0x5A; other regs unchanged; no tx_load.
3. Write frame 0x0F, 0x11, 0x22 with NUM_REGS=16 -> reg15 = 0x11, reg0 = 0x22 (wrap).
4. After test 2, read frame 0x83, dummy, dummy -> tx_load pulses 3 times; tx_data = 0xA5, 0x5A, then reg5.
5. Write 0x10, 0x77 with NUM_REGS=16 -> no register changes; addr_err pulses once.
6. Read 0x90 with NUM_REGS=16 -> tx_data = 0x00 and addr_err pulses on the command word.
7. cs_n forced high mid-frame after 0x02, then new frame 0x82 -> second frame decoded as a read command, not as data.
8. SPI_REG_BANK_WSTRB_EN defined -> in test 2, wr_stb pulses with wr_addr = 3, then 4.
